vga_frame_reader: RTL

- Display-side read stage for the camera frame buffer.
- Generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Maps a centred 320x240 window onto the 160x120 RGB565 frame buffer with 2x pixel replication and reads the buffer.
- Drives the time-overlay stage with an aligned 15-bit pixel address and 16-bit pixel colour, plus sync and data-enable.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_gen.sv | 60 ++++++
 rtl/vga_frame_reader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, bus widths and the per-pixel tag type
// used by the VGA frame-buffer read path.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_IMG_W  = 160;
    localparam int DEF_IMG_H  = 120;
    localparam int DEF_WIN_X0 = 160;
    localparam int DEF_WIN_Y0 = 120;

    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int CNT_W  = 10;
    localparam int ADDR_W = 15;
    localparam int RGB_W  = 16;

    localparam logic [ADDR_W-1:0] NO_PIXEL  = 15'h7FFF;
    localparam logic [RGB_W-1:0]  RGB_BLACK = 16'h0000;

    typedef struct packed {
        logic in_win;
        logic hsync;
        logic vsync;
        logic de;
        logic frame_start;
    } pix_tag_t;

    function automatic pix_tag_t idle_tag(input logic sync_pol);
        idle_tag = '{in_win: 1'b0, hsync: ~sync_pol, vsync: ~sync_pol,
                     de: 1'b0, frame_start: 1'b0};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical pixel counters with raw (undelayed) sync, data-enable
// and end-of-line / end-of-frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             de_raw,
    output logic             eol,
    output logic             eof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    assign eol = (hcnt == H_LAST);
    assign eof = eol && (vcnt == V_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (eol) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign hsync_raw = (hcnt >= HS_BEGIN && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign vsync_raw = (vcnt >= VS_BEGIN && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign de_raw    = (hcnt < H_ACT) && (vcnt < V_ACT);

endmodule

// File: rtl/vga_frame_reader.sv
// Display-side frame-buffer reader: VGA timing, 2x-replicated window address
// generation and a fixed 3-cycle pipeline aligning RAM data with sync/de.
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   IMG_W    = DEF_IMG_W,
    parameter int   IMG_H    = DEF_IMG_H,
    parameter int   WIN_X0   = DEF_WIN_X0,
    parameter int   WIN_Y0   = DEF_WIN_Y0,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [RGB_W-1:0]  ram_rdata,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [RGB_W-1:0]  pix_rgb,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0]  WIN_X_BEG = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0]  WIN_X_END = CNT_W'(WIN_X0 + 2 * IMG_W);
    localparam logic [CNT_W-1:0]  WIN_Y_BEG = CNT_W'(WIN_Y0);
    localparam logic [CNT_W-1:0]  WIN_Y_END = CNT_W'(WIN_Y0 + 2 * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam pix_tag_t          TAG_IDLE  = idle_tag(SYNC_POL);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              hsync_raw;
    logic              vsync_raw;
    logic              de_raw;
    logic              eol;
    logic              eof;

    logic              win_row;
    logic              in_win;
    logic              y_odd;
    logic [CNT_W-2:0]  x_half;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_d2;
    pix_tag_t          tag_now;
    pix_tag_t          tag_d1;
    pix_tag_t          tag_d2;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .de_raw    (de_raw),
        .eol       (eol),
        .eof       (eof)
    );

    assign win_row = (vcnt >= WIN_Y_BEG) && (vcnt < WIN_Y_END);
    assign in_win  = win_row && (hcnt >= WIN_X_BEG) && (hcnt < WIN_X_END);

    // Parity of (vcnt - WIN_Y0) without a subtractor: the second screen line
    // of each buffer row is the one that advances line_base.
    assign y_odd     = vcnt[0] ^ WIN_Y_BEG[0];
    assign x_half    = (CNT_W-1)'((hcnt - WIN_X_BEG) >> 1);
    assign addr_next = line_base + ADDR_W'(x_half);

    assign tag_now = '{in_win:      in_win,
                       hsync:       hsync_raw,
                       vsync:       vsync_raw,
                       de:          de_raw,
                       frame_start: (hcnt == '0) && (vcnt == '0)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_base <= '0;
        end else if (eof) begin
            line_base <= '0;
        end else if (eol && win_row && y_odd) begin
            line_base <= line_base + ROW_STEP;
        end
    end

    // Tags travel two stages to meet the RAM's one-cycle read latency, then
    // everything is registered together so all outputs share one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr    <= '0;
            tag_d1      <= TAG_IDLE;
            tag_d2      <= TAG_IDLE;
            addr_d2     <= '0;
            pix_addr    <= NO_PIXEL;
            pix_rgb     <= RGB_BLACK;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (in_win) begin
                ram_addr <= addr_next;
            end
            tag_d1      <= tag_now;
            tag_d2      <= tag_d1;
            addr_d2     <= ram_addr;
            pix_addr    <= tag_d2.in_win ? addr_d2   : NO_PIXEL;
            pix_rgb     <= tag_d2.in_win ? ram_rdata : RGB_BLACK;
            hsync       <= tag_d2.hsync;
            vsync       <= tag_d2.vsync;
            de          <= tag_d2.de;
            frame_start <= tag_d2.frame_start;
        end
    end

endmodule
